// File: rtl/comparator_scan_sequencer.sv
// Scan sequencer for the comparator pulse injector: steps halfstrips over a range,
// clears and fires the injector per point, and banks the three error counts.
module comparator_scan_sequencer #(
   parameter int unsigned CLEAR_CYCLES    = 2,
   parameter int unsigned SETTLE_CYCLES   = 4,
   parameter int unsigned WATCHDOG_CYCLES = 24'hFFFFFF
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        scan_start,
   input  logic        scan_abort,
   input  logic [4:0]  hs_first,
   input  logic [4:0]  hs_last,
   input  logic        mask_en_in,
   input  logic        pulser_ready,
   input  logic [15:0] thresholds_errcnt,
   input  logic [15:0] offsets_errcnt,
   input  logic [15:0] compout_errcnt,
   output logic        fire_pulse,
   output logic [4:0]  active_halfstrip,
   output logic        halfstrip_mask_en,
   output logic        thresholds_errcnt_rst,
   output logic        offsets_errcnt_rst,
   output logic        compout_errcnt_rst,
   output logic        scan_busy,
   output logic        scan_done,
   output logic        scan_timeout,
   output logic [5:0]  points_done,
   input  logic [4:0]  rd_addr,
   output logic [47:0] rd_data
);

   typedef enum logic [2:0] {
      IDLE, CLEAR, FIRE, WAIT_DONE, SETTLE, STORE, NEXT, ABORT
   } state_t;

   state_t      state;
   logic [4:0]  last_hs;
   logic [15:0] clr_cnt;
   logic [15:0] settle_cnt;
   logic [23:0] wd_cnt;
   logic        errcnt_clr;
   logic        wd_expired;
   logic [47:0] results [32];

   assign wd_expired            = (wd_cnt == 24'(WATCHDOG_CYCLES - 1));
   assign thresholds_errcnt_rst = errcnt_clr;
   assign offsets_errcnt_rst    = errcnt_clr;
   assign compout_errcnt_rst    = errcnt_clr;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state             <= IDLE;
         last_hs           <= '0;
         clr_cnt           <= '0;
         settle_cnt        <= '0;
         wd_cnt            <= '0;
         errcnt_clr        <= 1'b0;
         fire_pulse        <= 1'b0;
         active_halfstrip  <= '0;
         halfstrip_mask_en <= 1'b0;
         scan_busy         <= 1'b0;
         scan_done         <= 1'b0;
         scan_timeout      <= 1'b0;
         points_done       <= '0;
         for (int i = 0; i < 32; i++) results[i] <= '0;
      end else begin
         scan_done <= 1'b0;
         // Abort outranks every other transition once a scan is running.
         if (scan_abort && state != IDLE) begin
            fire_pulse <= 1'b0;
            errcnt_clr <= 1'b0;
            if (state != ABORT) wd_cnt <= '0;
            state <= ABORT;
         end else begin
            case (state)
               IDLE: begin
                  if (scan_start) begin
                     last_hs           <= hs_last;
                     halfstrip_mask_en <= mask_en_in;
                     active_halfstrip  <= hs_first;
                     scan_timeout      <= 1'b0;
                     points_done       <= '0;
                     clr_cnt           <= '0;
                     errcnt_clr        <= 1'b1;
                     scan_busy         <= 1'b1;
                     state             <= CLEAR;
                  end
               end
               CLEAR: begin
                  if (clr_cnt == 16'(CLEAR_CYCLES - 1)) begin
                     errcnt_clr <= 1'b0;
                     fire_pulse <= 1'b1;
                     wd_cnt     <= '0;
                     state      <= FIRE;
                  end else begin
                     clr_cnt <= clr_cnt + 16'd1;
                  end
               end
               FIRE: begin
                  if (!pulser_ready) begin
                     fire_pulse <= 1'b0;
                     wd_cnt     <= '0;
                     state      <= WAIT_DONE;
                  end else if (wd_expired) begin
                     fire_pulse   <= 1'b0;
                     scan_timeout <= 1'b1;
                     scan_busy    <= 1'b0;
                     state        <= IDLE;
                  end else begin
                     wd_cnt <= wd_cnt + 24'd1;
                  end
               end
               WAIT_DONE: begin
                  if (pulser_ready) begin
                     settle_cnt <= '0;
                     state      <= SETTLE;
                  end else if (wd_expired) begin
                     scan_timeout <= 1'b1;
                     scan_busy    <= 1'b0;
                     state        <= IDLE;
                  end else begin
                     wd_cnt <= wd_cnt + 24'd1;
                  end
               end
               SETTLE: begin
                  if (settle_cnt == 16'(SETTLE_CYCLES - 1)) state <= STORE;
                  else settle_cnt <= settle_cnt + 16'd1;
               end
               STORE: begin
                  results[active_halfstrip] <= {thresholds_errcnt, offsets_errcnt, compout_errcnt};
                  if (points_done != 6'd32) points_done <= points_done + 6'd1;
                  state <= NEXT;
               end
               NEXT: begin
                  if (active_halfstrip == last_hs) begin
                     scan_done <= 1'b1;
                     scan_busy <= 1'b0;
                     state     <= IDLE;
                  end else begin
                     active_halfstrip <= active_halfstrip + 5'd1;
                     clr_cnt          <= '0;
                     errcnt_clr       <= 1'b1;
                     state            <= CLEAR;
                  end
               end
               ABORT: begin
                  if (pulser_ready) begin
                     scan_busy <= 1'b0;
                     state     <= IDLE;
                  end else if (wd_expired) begin
                     scan_timeout <= 1'b1;
                     scan_busy    <= 1'b0;
                     state        <= IDLE;
                  end else begin
                     wd_cnt <= wd_cnt + 24'd1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   // Read sees the pre-store value when it hits the entry being written.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) rd_data <= '0;
      else          rd_data <= results[rd_addr];
   end

endmodule

// File: tb/tb_comparator_scan_sequencer.sv
// Directed bench for comparator_scan_sequencer with a small behavioural injector model.
module tb_comparator_scan_sequencer;

   localparam int BUSY = 20;

   logic        clock;
   logic        reset_n;
   logic        scan_start;
   logic        scan_abort;
   logic [4:0]  hs_first;
   logic [4:0]  hs_last;
   logic        mask_en_in;
   logic        pulser_ready;
   logic [15:0] thresholds_errcnt;
   logic [15:0] offsets_errcnt;
   logic [15:0] compout_errcnt;
   logic        fire_pulse;
   logic [4:0]  active_halfstrip;
   logic        halfstrip_mask_en;
   logic        thresholds_errcnt_rst;
   logic        offsets_errcnt_rst;
   logic        compout_errcnt_rst;
   logic        scan_busy;
   logic        scan_done;
   logic        scan_timeout;
   logic [5:0]  points_done;
   logic [4:0]  rd_addr;
   logic [47:0] rd_data;

   int errors = 0;
   int checks = 0;

   // Injector model controls
   bit model_stuck = 0;
   bit model_hold  = 0;
   int bias        = 0;

   // Monitor state
   int         done_cnt, fire_hi, rst_run, rst_min, rst_max, rst_split;
   logic [4:0] visited [$];
   logic       prev_rst;

   comparator_scan_sequencer #(
      .CLEAR_CYCLES(2),
      .SETTLE_CYCLES(4),
      .WATCHDOG_CYCLES(100)
   ) dut (
      .clock(clock),
      .reset_n(reset_n),
      .scan_start(scan_start),
      .scan_abort(scan_abort),
      .hs_first(hs_first),
      .hs_last(hs_last),
      .mask_en_in(mask_en_in),
      .pulser_ready(pulser_ready),
      .thresholds_errcnt(thresholds_errcnt),
      .offsets_errcnt(offsets_errcnt),
      .compout_errcnt(compout_errcnt),
      .fire_pulse(fire_pulse),
      .active_halfstrip(active_halfstrip),
      .halfstrip_mask_en(halfstrip_mask_en),
      .thresholds_errcnt_rst(thresholds_errcnt_rst),
      .offsets_errcnt_rst(offsets_errcnt_rst),
      .compout_errcnt_rst(compout_errcnt_rst),
      .scan_busy(scan_busy),
      .scan_done(scan_done),
      .scan_timeout(scan_timeout),
      .points_done(points_done),
      .rd_addr(rd_addr),
      .rd_data(rd_data)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [47:0] exp_entry(input int hs, input int b);
      logic [15:0] t, o, c;
      t = 16'(hs + 4 + b);
      o = 16'(hs - 1);
      c = 16'(hs - 3);
      return {t, o, c};
   endfunction

   // Injector: drops ready 3 cycles into a fire, stays busy BUSY cycles
   initial begin
      int fire_cnt, busy_cnt;
      fire_cnt = 0; busy_cnt = 0;
      pulser_ready = 1'b1;
      thresholds_errcnt = '0; offsets_errcnt = '0; compout_errcnt = '0;
      forever begin
         @(negedge clock);
         thresholds_errcnt = 16'(int'(active_halfstrip) + 4 + bias);
         offsets_errcnt    = 16'(int'(active_halfstrip) - 1);
         compout_errcnt    = 16'(int'(active_halfstrip) - 3);
         if (!reset_n || model_stuck) begin
            pulser_ready = 1'b1; fire_cnt = 0; busy_cnt = 0;
         end else if (busy_cnt > 0) begin
            if (!model_hold) begin
               busy_cnt--;
               if (busy_cnt == 0) pulser_ready = 1'b1;
            end
         end else if (fire_pulse) begin
            fire_cnt++;
            if (fire_cnt == 3) begin
               pulser_ready = 1'b0; busy_cnt = BUSY; fire_cnt = 0;
            end
         end else begin
            fire_cnt = 0;
         end
      end
   end

   initial begin
      prev_rst = 1'b0; done_cnt = 0; fire_hi = 0; rst_run = 0;
      rst_min = 1000; rst_max = 0; rst_split = 0;
      forever begin
         @(negedge clock);
         if (thresholds_errcnt_rst && !prev_rst) visited.push_back(active_halfstrip);
         if (thresholds_errcnt_rst) rst_run++;
         else if (prev_rst) begin
            if (rst_run < rst_min) rst_min = rst_run;
            if (rst_run > rst_max) rst_max = rst_run;
            rst_run = 0;
         end
         if (thresholds_errcnt_rst !== offsets_errcnt_rst ||
             thresholds_errcnt_rst !== compout_errcnt_rst) rst_split++;
         if (scan_done) done_cnt++;
         if (fire_pulse) fire_hi++;
         prev_rst = thresholds_errcnt_rst;
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
      $fatal(1, "bench time limit");
   end

   task automatic clear_mon();
      done_cnt = 0; fire_hi = 0; rst_min = 1000; rst_max = 0; rst_split = 0;
      visited.delete();
   endtask

   task automatic start_scan(input logic [4:0] f, input logic [4:0] l, input logic m);
      @(negedge clock);
      hs_first = f; hs_last = l; mask_en_in = m; scan_start = 1'b1;
      @(negedge clock);
      scan_start = 1'b0;
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         if (!scan_busy) begin ok = 1; break; end
         @(negedge clock);
      end
   endtask

   task automatic read_entry(input logic [4:0] a, output logic [47:0] d);
      @(negedge clock);
      rd_addr = a;
      @(negedge clock);
      d = rd_data;
   endtask

   task automatic test_reset();
      logic [47:0] d;
      scan_start = 0; scan_abort = 0; hs_first = 0; hs_last = 0; mask_en_in = 0; rd_addr = 0;
      reset_n = 1'b0;
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      checks++;
      if ({fire_pulse, active_halfstrip, halfstrip_mask_en, thresholds_errcnt_rst,
           offsets_errcnt_rst, compout_errcnt_rst, scan_busy, scan_done, scan_timeout,
           points_done} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: fire=%b hs=%0d mask=%b rst=%b%b%b busy=%b done=%b to=%b pts=%0d, required all 0",
                  fire_pulse, active_halfstrip, halfstrip_mask_en, thresholds_errcnt_rst,
                  offsets_errcnt_rst, compout_errcnt_rst, scan_busy, scan_done, scan_timeout, points_done);
      end
      read_entry(5'd17, d);
      checks++;
      if (d !== 48'h0) begin
         errors++;
         $display("FAIL reset_rd_data: got %h, required 0", d);
      end
   endtask

   task automatic test_basic_scan();
      bit ok;
      logic [47:0] d, e;
      clear_mon();
      start_scan(5'd3, 5'd5, 1'b1);
      wait_idle(600, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL basic_complete: busy still 1, required 0"); end
      checks++;
      if (visited.size() !== 3 || visited[0] !== 5'd3 || visited[1] !== 5'd4 || visited[2] !== 5'd5) begin
         errors++;
         $display("FAIL basic_order: %0d points visited, required 3 on 3,4,5", visited.size());
      end
      checks++;
      if (done_cnt !== 1) begin errors++; $display("FAIL basic_done: %0d pulse cycles, required 1", done_cnt); end
      checks++;
      if (points_done !== 6'd3) begin errors++; $display("FAIL basic_points: got %0d, required 3", points_done); end
      checks++;
      if (rst_min !== 2 || rst_max !== 2 || rst_split !== 0) begin
         errors++;
         $display("FAIL basic_clear_len: min=%0d max=%0d split=%0d, required 2 2 0", rst_min, rst_max, rst_split);
      end
      checks++;
      if (active_halfstrip !== 5'd5 || halfstrip_mask_en !== 1'b1) begin
         errors++;
         $display("FAIL basic_hold: hs=%0d mask=%b, required 5 1", active_halfstrip, halfstrip_mask_en);
      end
      read_entry(5'd3, d);
      checks++;
      if (d !== 48'h0007_0002_0000) begin errors++; $display("FAIL basic_hs3: got %h, required 000700020000", d); end
      for (int i = 0; i < 32; i++) begin
         read_entry(5'(i), d);
         e = (i >= 3 && i <= 5) ? exp_entry(i, 0) : 48'h0;
         checks++;
         if (d !== e) begin errors++; $display("FAIL basic_entry%0d: got %h, required %h", i, d, e); end
      end
   endtask

   task automatic test_wrap_scan();
      bit ok;
      logic [47:0] d;
      logic [4:0] pts [4];
      pts[0] = 5'd30; pts[1] = 5'd31; pts[2] = 5'd0; pts[3] = 5'd1;
      clear_mon();
      start_scan(5'd30, 5'd1, 1'b0);
      wait_idle(900, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL wrap_complete: busy still 1, required 0"); end
      checks++;
      if (visited.size() !== 4) begin errors++; $display("FAIL wrap_count: got %0d, required 4", visited.size()); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (visited.size() > i && visited[i] !== pts[i]) begin
            errors++;
            $display("FAIL wrap_order%0d: got %0d, required %0d", i, visited[i], pts[i]);
         end
      end
      checks++;
      if (points_done !== 6'd4 || halfstrip_mask_en !== 1'b0) begin
         errors++;
         $display("FAIL wrap_points: pts=%0d mask=%b, required 4 0", points_done, halfstrip_mask_en);
      end
      for (int i = 0; i < 4; i++) begin
         read_entry(pts[i], d);
         checks++;
         if (d !== exp_entry(int'(pts[i]), 0)) begin
            errors++;
            $display("FAIL wrap_entry%0d: got %h, required %h", pts[i], d, exp_entry(int'(pts[i]), 0));
         end
      end
   endtask

   task automatic test_watchdog();
      bit ok;
      logic [47:0] d;
      model_stuck = 1;
      clear_mon();
      start_scan(5'd10, 5'd10, 1'b0);
      wait_idle(400, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL wd_idle: busy still 1, required 0"); end
      checks++;
      if (fire_hi !== 100) begin errors++; $display("FAIL wd_fire_len: got %0d cycles, required 100", fire_hi); end
      checks++;
      if (scan_timeout !== 1'b1 || fire_pulse !== 1'b0) begin
         errors++;
         $display("FAIL wd_flag: timeout=%b fire=%b, required 1 0", scan_timeout, fire_pulse);
      end
      checks++;
      if (done_cnt !== 0 || points_done !== 6'd0) begin
         errors++;
         $display("FAIL wd_nostore: done=%0d pts=%0d, required 0 0", done_cnt, points_done);
      end
      read_entry(5'd10, d);
      checks++;
      if (d !== 48'h0) begin errors++; $display("FAIL wd_entry: got %h, required 0", d); end
      model_stuck = 0;
      start_scan(5'd10, 5'd10, 1'b0);
      checks++;
      if (scan_timeout !== 1'b0 || scan_busy !== 1'b1) begin
         errors++;
         $display("FAIL wd_restart: timeout=%b busy=%b, required 0 1", scan_timeout, scan_busy);
      end
      wait_idle(300, ok);
      read_entry(5'd10, d);
      checks++;
      if (d !== exp_entry(10, 0)) begin errors++; $display("FAIL wd_rescan: got %h, required %h", d, exp_entry(10, 0)); end
   endtask

   task automatic test_abort();
      bit ok, held;
      logic [47:0] d;
      int n;
      bias = 100;
      model_hold = 1;
      clear_mon();
      start_scan(5'd4, 5'd4, 1'b1);
      n = 0;
      while (fire_pulse !== 1'b1 && n < 50) begin @(negedge clock); n++; end
      while (fire_pulse !== 1'b0 && n < 100) begin @(negedge clock); n++; end
      checks++;
      if (n >= 100) begin errors++; $display("FAIL abort_reach_wait: fire never completed, required fire then release"); end
      scan_abort = 1'b1;
      @(negedge clock);
      scan_abort = 1'b0;
      held = 1;
      for (int i = 0; i < 10; i++) begin
         if (fire_pulse !== 1'b0 || scan_busy !== 1'b1) held = 0;
         @(negedge clock);
      end
      checks++;
      if (!held) begin errors++; $display("FAIL abort_hold: fire/busy left 0/1, required fire=0 busy=1"); end
      model_hold = 0;
      wait_idle(200, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL abort_idle: busy still 1, required 0"); end
      checks++;
      if (done_cnt !== 0 || scan_timeout !== 1'b0) begin
         errors++;
         $display("FAIL abort_flags: done=%0d timeout=%b, required 0 0", done_cnt, scan_timeout);
      end
      bias = 0;
      read_entry(5'd4, d);
      checks++;
      if (d !== exp_entry(4, 0)) begin errors++; $display("FAIL abort_entry: got %h, required %h", d, exp_entry(4, 0)); end
   endtask

   task automatic test_start_abort_same();
      bit ok;
      logic [47:0] d;
      @(negedge clock);
      scan_abort = 1'b1;
      @(negedge clock);
      scan_abort = 1'b0;
      checks++;
      if (scan_busy !== 1'b0) begin errors++; $display("FAIL idle_abort: busy=%b, required 0", scan_busy); end
      clear_mon();
      @(negedge clock);
      hs_first = 5'd7; hs_last = 5'd7; mask_en_in = 1'b0;
      scan_start = 1'b1; scan_abort = 1'b1;
      @(negedge clock);
      scan_start = 1'b0; scan_abort = 1'b0;
      checks++;
      if (scan_busy !== 1'b1) begin errors++; $display("FAIL start_abort_busy: busy=%b, required 1", scan_busy); end
      wait_idle(300, ok);
      checks++;
      if (done_cnt !== 1 || points_done !== 6'd1) begin
         errors++;
         $display("FAIL start_abort_done: done=%0d pts=%0d, required 1 1", done_cnt, points_done);
      end
      read_entry(5'd7, d);
      checks++;
      if (d !== exp_entry(7, 0)) begin errors++; $display("FAIL start_abort_entry: got %h, required %h", d, exp_entry(7, 0)); end
   endtask

   task automatic test_async_reset();
      logic [47:0] d;
      logic [4:0] a [4];
      int n;
      a[0] = 5'd3; a[1] = 5'd5; a[2] = 5'd10; a[3] = 5'd31;
      start_scan(5'd12, 5'd12, 1'b1);
      n = 0;
      while (fire_pulse !== 1'b1 && n < 50) begin @(negedge clock); n++; end
      checks++;
      if (n >= 50) begin errors++; $display("FAIL areset_fire: fire never rose, required 1"); end
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if ({fire_pulse, active_halfstrip, halfstrip_mask_en, thresholds_errcnt_rst, scan_busy,
           scan_done, scan_timeout, points_done, rd_data} !== '0) begin
         errors++;
         $display("FAIL areset_outputs: fire=%b hs=%0d mask=%b busy=%b pts=%0d rd=%h, required all 0",
                  fire_pulse, active_halfstrip, halfstrip_mask_en, scan_busy, points_done, rd_data);
      end
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         read_entry(a[i], d);
         checks++;
         if (d !== 48'h0) begin errors++; $display("FAIL areset_entry%0d: got %h, required 0", a[i], d); end
      end
   endtask

   initial begin
      test_reset();
      test_basic_scan();
      test_wrap_scan();
      test_watchdog();
      test_abort();
      test_start_abort_same();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
